// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port round-robin arbiter in front of a single-port data memory.
// Each granted access runs IDLE -> ACC -> WAIT -> DONE, so a request sampled in
// IDLE completes with a done pulse three cycles later.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   req0/1, we0/1            per-port request (held until done) and access type (1 = write)
//   addr0/1, wdata0/1        per-port word address and write data
//   gnt0/1, done0/1          per-port one-cycle grant (ACC) and completion (DONE) pulses
//   rdata0/1                 per-port registered read data, valid in the done cycle
//   err                      address-out-of-range flag, valid in the done cycle
//   we_DM, addrDM, dataDM    data-memory write enable, address, write data
//   outDM                    data-memory read data (registered by the memory)
//
// state | meaning
// IDLE  | waiting for a request; addrDM/dataDM hold the last access
// ACC   | memory access cycle; gnt pulse; write strobe for an in-range write
// WAIT  | memory read data presented on outDM; captured into rdata at exit
// DONE  | done pulse and err flag for the selected port
module dm_arbiter #(
  parameter logic [15:0] ADDR_MAX = 16'd1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic        err,
  output logic        we_DM,
  output logic [15:0] addrDM,
  output logic [15:0] dataDM,
  input  logic [15:0] outDM
);

  typedef enum logic [1:0] {IDLE, ACC, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic        sel_q;      // port index of the transaction in flight
  logic        last_q;     // port index granted most recently
  logic        we_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        sel_nxt;
  logic        start;
  logic        oor;

  assign oor   = (addr_q > ADDR_MAX);
  assign start = (state == IDLE) && (req0 || req1);

  // With both ports requesting, the one not granted last wins.
  always_comb begin
    sel_nxt = 1'b0;
    if (req0 && req1) sel_nxt = ~last_q;
    else if (req1)    sel_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0 || req1) state_nxt = ACC;
      ACC:     state_nxt = WAIT;
      WAIT:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction capture; addr_q/wdata_q drive the memory bus directly and so
  // hold their values through IDLE until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (start) begin
      sel_q   <= sel_nxt;
      last_q  <= sel_nxt;
      we_q    <= sel_nxt ? we1    : we0;
      addr_q  <= sel_nxt ? addr1  : addr0;
      wdata_q <= sel_nxt ? wdata1 : wdata0;
    end
  end

  // Out-of-range reads return zero instead of whatever the memory produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (state == WAIT && !we_q) begin
      if (sel_q) rdata1 <= oor ? 16'h0000 : outDM;
      else       rdata0 <= oor ? 16'h0000 : outDM;
    end
  end

  // Strobes decode from the state register so an asynchronous reset removes
  // them at once.
  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    done0 = 1'b0;
    done1 = 1'b0;
    err   = 1'b0;
    we_DM = 1'b0;
    case (state)
      ACC: begin
        gnt0  = ~sel_q;
        gnt1  = sel_q;
        we_DM = we_q && !oor;
      end
      DONE: begin
        done0 = ~sel_q;
        done1 = sel_q;
        err   = oor;
      end
      default: ;
    endcase
  end

  assign addrDM = addr_q;
  assign dataDM = wdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, done0, done1, err, we_DM;
  logic [15:0] rdata0, rdata1, addrDM, dataDM;
  logic [15:0] outDM = '0;

  int n_pass = 0;
  int n_total = 0;
  int we_cnt = 0;

  typedef struct {
    int          port;
    logic [15:0] rd;
    logic        er;
  } exp_t;
  exp_t sb[$];

  logic [15:0] mem [0:2047];
  logic        mem_init = 1'b0;

  always #5 clk = ~clk;

  dm_arbiter #(.ADDR_MAX(16'd1023)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1), .err(err),
    .we_DM(we_DM), .addrDM(addrDM), .dataDM(dataDM), .outDM(outDM)
  );

  // Synchronous single-port memory: write when we_DM, otherwise register a read.
  always @(posedge clk) begin
    if (!mem_init) begin
      mem[0]    <= 16'h0000;
      mem[6]    <= 16'h0666;
      mem[10]   <= 16'h1234;
      mem[11]   <= 16'h5678;
      mem[20]   <= 16'h2020;
      mem[1024] <= 16'h5A5A;
      mem_init  <= 1'b1;
    end else if (we_DM) begin
      mem[addrDM[10:0]] <= dataDM;
    end else begin
      outDM <= mem[addrDM[10:0]];
    end
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Scoreboard monitor: every done pulse pops one expected completion.
  always @(negedge clk) begin
    if (we_DM) we_cnt++;
    if (rst_n && (done0 || done1)) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {30'd0, done1, done0}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_port", {31'd0, done1}, (e.port == 1) ? 32'd1 : 32'd0);
        chk("done_onehot", {31'd0, done0 & done1}, 32'd0);
        chk("done_err", {31'd0, err}, {31'd0, e.er});
        chk("done_rdata", {16'd0, (e.port == 1) ? rdata1 : rdata0}, {16'd0, e.rd});
      end
    end
  end

  task automatic drive(input int p, input logic r, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  // One transaction on port p; checks grant/strobe timing in-line, while the
  // completion data is checked by the monitor.
  task automatic txn(input int p, input logic w, input logic [15:0] a,
                     input logic [15:0] d, input logic [15:0] exp_rd,
                     input logic exp_err, input logic scramble);
    exp_t e;
    e.port = p; e.rd = exp_rd; e.er = exp_err;
    sb.push_back(e);
    @(negedge clk);
    drive(p, 1'b1, w, a, d);
    @(negedge clk);                                 // ACC
    chk("gnt_sel", {30'd0, gnt1, gnt0}, (p == 1) ? 32'd2 : 32'd1);
    chk("acc_we_DM", {31'd0, we_DM}, {31'd0, w & ~exp_err});
    chk("acc_addrDM", {16'd0, addrDM}, {16'd0, a});
    chk("acc_err", {31'd0, err}, 32'd0);
    if (scramble) drive(p, 1'b1, 1'b1, 16'd6, 16'hFFFF);
    @(negedge clk);                                 // WAIT
    chk("wait_strobes", {28'd0, we_DM, gnt1, gnt0, err}, 32'd0);
    chk("wait_addrDM", {16'd0, addrDM}, {16'd0, a});
    @(negedge clk);                                 // DONE
    chk("done_latency", {30'd0, done1, done0}, (p == 1) ? 32'd2 : 32'd1);
    drive(p, 1'b0, 1'b0, 16'd0, 16'd0);
    @(negedge clk);                                 // IDLE
    chk("idle_quiet", {26'd0, done1, done0, gnt1, gnt0, we_DM, err}, 32'd0);
    chk("idle_addr_hold", {16'd0, addrDM}, {16'd0, a});
  endtask

  initial begin
    #1;
    chk("rst_strobes", {26'd0, gnt0, gnt1, done0, done1, err, we_DM}, 32'd0);
    chk("rst_bus", {addrDM, dataDM}, 32'd0);
    chk("rst_rdata", {rdata0, rdata1}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Port-0 write then read-back.
    we_cnt = 0;
    txn(0, 1'b1, 16'd5, 16'h1DFE, 16'h0000, 1'b0, 1'b0);
    chk("write_pulse_count", we_cnt, 32'd1);
    txn(0, 1'b0, 16'd5, 16'h0000, 16'h1DFE, 1'b0, 1'b0);
    chk("read_no_write", we_cnt, 32'd1);

    // Port-1 read, then out-of-range write/read at the boundary+1.
    txn(1, 1'b0, 16'd11, 16'h0000, 16'h5678, 1'b0, 1'b0);
    txn(1, 1'b1, 16'd1024, 16'hA001, 16'h5678, 1'b1, 1'b0);
    chk("oor_no_write", we_cnt, 32'd1);
    chk("oor_mem_intact", {16'd0, mem[1024]}, 32'h5A5A);
    txn(1, 1'b0, 16'd1024, 16'h0000, 16'h0000, 1'b1, 1'b0);
    // Highest valid address is in range.
    txn(1, 1'b1, 16'd1023, 16'hBEEF, 16'h0000, 1'b0, 1'b0);
    txn(1, 1'b0, 16'd1023, 16'h0000, 16'hBEEF, 1'b0, 1'b0);

    // Port-0 inputs changed mid-transaction: the latched read still wins.
    txn(0, 1'b0, 16'd5, 16'h0000, 16'h1DFE, 1'b0, 1'b1);
    chk("scramble_mem6", {16'd0, mem[6]}, 32'h0666);

    // Reset pulsed during the ACC cycle of a write.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 16'd20, 16'hDEAD);
    @(negedge clk);
    chk("rst_acc_we_before", {31'd0, we_DM}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_strobes", {26'd0, gnt0, gnt1, done0, done1, err, we_DM}, 32'd0);
    chk("rst_async_bus", {addrDM, dataDM}, 32'd0);
    chk("rst_async_rdata", {rdata0, rdata1}, 32'd0);
    drive(0, 1'b0, 1'b0, 16'd0, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mem_intact", {16'd0, mem[20]}, 32'h2020);
    txn(1, 1'b1, 16'd21, 16'hC0DE, 16'h0000, 1'b0, 1'b0);
    txn(1, 1'b0, 16'd21, 16'h0000, 16'hC0DE, 1'b0, 1'b0);

    // Both ports requesting continuously: alternating grants every 4 cycles.
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      e.port = i % 2;
      e.rd   = (i % 2 == 1) ? 16'h5678 : 16'h1234;
      e.er   = 1'b0;
      sb.push_back(e);
    end
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'd10, 16'd0);
    drive(1, 1'b1, 1'b0, 16'd11, 16'd0);
    for (int k = 1; k <= 23; k++) begin
      logic [1:0] exp_g;
      @(negedge clk);
      exp_g = 2'b00;
      if ((k - 1) % 4 == 0) exp_g = (((k - 1) / 4) % 2 == 1) ? 2'b10 : 2'b01;
      chk($sformatf("rr_gnt_k%0d", k), {30'd0, gnt1, gnt0}, {30'd0, exp_g});
      if (k == 23) begin
        drive(0, 1'b0, 1'b0, 16'd0, 16'd0);
        drive(1, 1'b0, 1'b0, 16'd0, 16'd0);
      end
    end
    repeat (4) @(negedge clk);
    chk("rr_idle_no_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
